// File: rtl/mem_bist_ctrl.sv
// Built-in self-test controller for a single-port synchronous memory: writes a
// generated pattern to every location, reads it back and compares in hardware.
module mem_bist_ctrl #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ERR_W  = 8,
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(8'hB8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t              state, state_d;
    logic [ADDR_W-1:0]   addr, addr_d;
    logic [DATA_W-1:0]   lfsr, lfsr_d, lfsr_nx;
    logic [1:0]          mode_q, mode_q_d;
    logic [DATA_W-1:0]   seed_q, seed_q_d, seed_eff;
    logic                cmp_vld, cmp_vld_d;
    logic [ADDR_W-1:0]   cmp_addr, cmp_addr_d;
    logic [DATA_W-1:0]   cmp_exp, cmp_exp_d;
    logic                busy_d, done_d, pass_d, mem_write_d, mem_read_d;
    logic [ERR_W-1:0]    err_d;
    logic [ADDR_W-1:0]   fail_addr_d, mem_addr_d;
    logic [DATA_W-1:0]   fail_exp_d, fail_got_d, mem_wdata_d;

    // Right-shifting Galois LFSR step.
    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] l);
        return l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
    endfunction

    // Data pattern for a location; the LFSR value is only used in mode 2.
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                   input logic [ADDR_W-1:0] a,
                                                   input logic [DATA_W-1:0] l);
        logic [DATA_W-1:0] r;
        r = '0;
        case (m)
            2'd0: r = '0;
            2'd1: r = DATA_W'(a);
            2'd2: r = l;
            2'd3: for (int i = 0; i < int'(DATA_W); i++) r[i] = ~(i[0] ^ a[0]);
            default: r = '0;
        endcase
        return r;
    endfunction

    assign lfsr_nx  = lfsr_step(lfsr);
    assign seed_eff = (seed == '0) ? '1 : seed;

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state;
        addr_d      = addr;
        lfsr_d      = lfsr;
        mode_q_d    = mode_q;
        seed_q_d    = seed_q;
        cmp_vld_d   = 1'b0;
        cmp_addr_d  = cmp_addr;
        cmp_exp_d   = cmp_exp;
        busy_d      = busy;
        done_d      = 1'b0;
        pass_d      = pass;
        err_d       = err_count;
        fail_addr_d = fail_addr;
        fail_exp_d  = fail_exp;
        fail_got_d  = fail_got;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;

        // Compare the read data returned for the previous read cycle.
        if (cmp_vld && (mem_rdata != cmp_exp)) begin
            if (err_count != ERR_MAX) err_d = err_count + ERR_W'(1);
            if (err_count == '0) begin
                fail_addr_d = cmp_addr;
                fail_exp_d  = cmp_exp;
                fail_got_d  = mem_rdata;
            end
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_d     = WRITE;
                    mode_q_d    = mode;
                    seed_q_d    = seed_eff;
                    err_d       = '0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_got_d  = '0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    addr_d      = '0;
                    lfsr_d      = seed_eff;
                    mem_write_d = 1'b1;
                    mem_addr_d  = '0;
                    mem_wdata_d = pattern(mode, '0, seed_eff);
                end
            end
            WRITE: begin
                if (addr == LAST_ADDR) begin
                    state_d    = READ;
                    addr_d     = '0;
                    lfsr_d     = seed_q;
                    mem_read_d = 1'b1;
                    mem_addr_d = '0;
                end else begin
                    addr_d      = addr + ADDR_W'(1);
                    lfsr_d      = lfsr_nx;
                    mem_write_d = 1'b1;
                    mem_addr_d  = addr + ADDR_W'(1);
                    mem_wdata_d = pattern(mode_q, addr + ADDR_W'(1), lfsr_nx);
                end
            end
            READ: begin
                cmp_vld_d  = 1'b1;
                cmp_addr_d = addr;
                cmp_exp_d  = pattern(mode_q, addr, lfsr);
                lfsr_d     = lfsr_nx;
                if (addr == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    addr_d     = addr + ADDR_W'(1);
                    mem_read_d = 1'b1;
                    mem_addr_d = addr + ADDR_W'(1);
                end
            end
            DRAIN: begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_d == '0);
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            lfsr      <= '0;
            mode_q    <= '0;
            seed_q    <= '0;
            cmp_vld   <= 1'b0;
            cmp_addr  <= '0;
            cmp_exp   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
        end else begin
            state     <= state_d;
            addr      <= addr_d;
            lfsr      <= lfsr_d;
            mode_q    <= mode_q_d;
            seed_q    <= seed_q_d;
            cmp_vld   <= cmp_vld_d;
            cmp_addr  <= cmp_addr_d;
            cmp_exp   <= cmp_exp_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            err_count <= err_d;
            fail_addr <= fail_addr_d;
            fail_exp  <= fail_exp_d;
            fail_got  <= fail_got_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_write <= mem_write_d;
            mem_read  <= mem_read_d;
        end
    end

endmodule

// File: doc/mem_bist_ctrl.md
# mem_bist_ctrl

Parametrised, synthesizable built-in self-test controller for the single-port synchronous memory on the `mem` interface. It generates its own address and data stimulus, writes every location, reads every location back, and compares the result in hardware. It keeps an error count and captures the first failure. Four data modes are supported: clear, address-as-data, LFSR pseudo-random and checkerboard. It replaces testbench-only random write/read-back checking, so the same check can run in both simulation and silicon.

## Interface
- ADDR_W, 5, memory address width; DEPTH = 2**ADDR_W
- DATA_W, 8, memory data width (≥ 2)
- ERR_W, 8, error counter width
- LFSR_TAPS, 8'hB8, Galois LFSR feedback mask, DATA_W bits

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a test run; sampled only in IDLE
- mode  in  2  0=clear (0), 1=address-as-data, 2=LFSR, 3=checkerboard
- seed  in  DATA_W  LFSR seed, sampled with start; zero is replaced by all-ones
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at end of run
- pass  out  1  valid from done until the next accepted start; 1 = err_count==0
- err_count  out  ERR_W  saturating mismatch count
- fail_addr  out  ADDR_W  address of the first mismatch
- fail_exp  out  DATA_W  expected data at the first mismatch
- fail_got  out  DATA_W  read data at the first mismatch
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_write  out  1  memory write strobe
- mem_read  out  1  memory read strobe
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_read

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - on start=1, latch mode and seed (zero→all-ones) and clear err_count, fail_* and pass.
  - Load the address counter with 0 and the LFSR with the seed, then go to WRITE.
- WRITE: drive mem_write=1, mem_addr=addr, mem_wdata=pattern(addr), one location per cycle.
  - Advance the LFSR each cycle.
  - When addr reaches DEPTH-1, wrap addr to 0, reload the LFSR from the latched seed, and go to READ.
- READ:
  - Drive mem_read=1 and mem_addr=addr, and advance the LFSR.
  - Register the expected data and address into a 1-stage compare pipeline (cmp_vld, cmp_addr, cmp_exp).
  - At DEPTH-1, go to DRAIN.
- DRAIN: no memory strobes; the last pipeline entry is compared. Go to DONE.
- DONE: done=1 for one cycle, busy=0, pass=(err_count==0). Go to IDLE.
- Compare, active whenever cmp_vld=1:
  - On mismatch (mem_rdata != cmp_exp), increment err_count, saturating at 2**ERR_W-1.
  - If this is the first mismatch of the run, capture fail_addr, fail_exp and fail_got.
- Patterns:
  - mode0: 0.
  - mode1: addr zero-extended, or truncated to DATA_W.
  - mode2: current LFSR state. The Galois shift is right: lsb out, XOR LFSR_TAPS when lsb=1.
  - mode3: alternating 0101… when addr[0]=0, 1010… when addr[0]=1.
- start while busy is ignored; mode/seed changes mid-run are ignored.
- mem_write and mem_read are never high in the same cycle.

## Timing
- Reset values, all outputs: busy=0, done=0, pass=0, err_count=0, fail_*=0, mem_addr=0, mem_wdata=0, mem_write=0, mem_read=0. State goes to IDLE.
- Run timing, with start sampled at edge T:
  - WRITE occupies cycles T+1..T+DEPTH.
  - READ occupies T+DEPTH+1..T+2·DEPTH.
  - DRAIN is cycle T+2·DEPTH+1; done is high in cycle T+2·DEPTH+2.
  - DEPTH=32 gives done 66 cycles after start.
- Compare latency: one cycle after each mem_read cycle.
- Reset asserted mid-run aborts immediately to reset values. No done pulse is produced, and the memory contents are left undefined.
- A saturated err_count holds; pass=0.
- The first-failure capture is not overwritten by later mismatches.

## Test plan
- Clean memory, mode1, DEPTH=32:
  - Expect 32 writes with data==addr, then 32 reads.
  - done at start+66, pass=1, err_count=0.
- Clean memory, mode2, seed=8'h00:
  - The write-data sequence starts 8'hFF and follows LFSR_TAPS.
  - The read-phase expected data sequence is identical; pass=1.
- Memory model with bit 3 stuck-at-1, mode0: err_count=32, pass=0, fail_addr=0, fail_exp=8'h00, fail_got=8'h08.
- Model corrupting only addr 17 (read returns wdata^8'h01), mode3: err_count=1, fail_addr=17, fail_exp=8'hAA, fail_got=8'hAB.
- ERR_W=4, stuck-at model, mode0: err_count saturates at 15, pass=0.
- Control cases:
  - start pulsed during WRITE has no effect.
  - rst at cycle start+10 gives all outputs zero, with no done.
  - A following start runs a full run that ends with pass=1.
